// File: rtl/score_render_ctrl_if.sv
// Font ROM bus: score_render_ctrl drives the address, the registered glyph ROM
// returns the 8-bit row bitmap one edge after sampling it.
interface score_render_ctrl_if;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/score_render_ctrl.sv
// BCD score field renderer: prefetches one glyph row per digit in hblank, shifts pixels in active video.
// Optional macro SCORE_LZB_EN enables leading-zero blanking (blank glyph code 0xF).
module score_render_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int X0         = 16,
    parameter int Y0         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] score_bcd,
    input  logic                    score_valid,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic [9:0]              line_y,
    input  logic [9:0]              pixel_x,
    input  logic                    pixel_active,
    score_render_ctrl_if.master     rom,
    output logic                    busy,
    output logic                    pixel_on
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [9:0]       Y_LO     = 10'(Y0);
    localparam logic [9:0]       Y_HI     = 10'(Y0 + 16);
    localparam logic [3:0]       Y_LO4    = 4'(Y0);
    localparam logic [9:0]       X_LO     = 10'(X0);
    localparam logic [9:0]       X_HI     = 10'(X0 + 8 * NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              row_q, row_d;
    logic [7:0]              rom_addr_q, rom_addr_d;
    logic                    iss_vld_q, iss_vld_d;
    logic [IDX_W-1:0]        iss_idx_q, iss_idx_d;
    logic                    cap_vld_q, cap_vld_d;
    logic [IDX_W-1:0]        cap_idx_q, cap_idx_d;
    logic                    busy_q, busy_d;
    logic                    pixel_on_q, pixel_on_d;
    logic [4*NUM_DIGITS-1:0] pending_q, shadow_q;
    logic [3:0]              code_w    [NUM_DIGITS];
    logic [7:0]              work_q    [NUM_DIGITS];
    logic [7:0]              display_q [NUM_DIGITS];

    logic       disp_load, disp_clear;
    logic       in_field, start;
    logic [3:0] row_new, issue_code;
    logic [9:0] x_off;
    logic       in_x, pix_bit;

    // Shadow only moves on frame_start, so a frame never mixes two scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            shadow_q  <= '0;
        end else begin
            if (score_valid) pending_q <= score_bcd;
            if (frame_start) shadow_q  <= pending_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
            logic [3:0] nib;
            assign nib = shadow_q[4*(NUM_DIGITS-1-gi) +: 4];
`ifdef SCORE_LZB_EN
            if (gi == NUM_DIGITS - 1) begin : g_last
                assign code_w[gi] = nib;
            end else begin : g_lead
                assign code_w[gi] = (shadow_q[4*NUM_DIGITS-1 -: 4*(gi+1)] == '0) ? 4'hF : nib;
            end
`else
            assign code_w[gi] = nib;
`endif
        end
    endgenerate

    always_comb begin
        issue_code = code_w[0];
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) issue_code = code_w[d];
        end
    end

    assign in_field = (line_y >= Y_LO) && (line_y < Y_HI);
    assign start    = line_start && in_field;
    assign row_new  = line_y[3:0] - Y_LO4;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        iss_vld_d  = 1'b0;
        iss_idx_d  = idx_q;
        cap_vld_d  = iss_vld_q;
        cap_idx_d  = iss_idx_q;
        disp_load  = 1'b0;
        disp_clear = 1'b0;
        busy_d     = start || ((state_q != IDLE) && !line_start);

        if (line_start) begin
            // Any line_start kills in-flight captures; a new line restarts from digit 0.
            cap_vld_d = 1'b0;
            if (in_field) begin
                row_d      = row_new;
                rom_addr_d = {code_w[0], row_new};
                iss_vld_d  = 1'b1;
                iss_idx_d  = '0;
                idx_d      = IDX_W'(1);
                state_d    = (NUM_DIGITS == 1) ? DRAIN : FETCH;
            end else begin
                disp_clear = 1'b1;
                state_d    = IDLE;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    rom_addr_d = {issue_code, row_q};
                    iss_vld_d  = 1'b1;
                    iss_idx_d  = idx_q;
                    idx_d      = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) state_d = DRAIN;
                end
                DRAIN: begin
                    if (cap_vld_q && (cap_idx_q == LAST_IDX)) begin
                        disp_load = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            rom_addr_q <= '0;
            iss_vld_q  <= 1'b0;
            iss_idx_q  <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            busy_q     <= 1'b0;
            pixel_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr_d;
            iss_vld_q  <= iss_vld_d;
            iss_idx_q  <= iss_idx_d;
            cap_vld_q  <= cap_vld_d;
            cap_idx_q  <= cap_idx_d;
            busy_q     <= busy_d;
            pixel_on_q <= pixel_on_d;
        end
    end

    // The last digit goes straight from the ROM into display, so the whole line swaps in one edge.
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_buf
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    work_q[gi] <= '0;
                end else if (cap_vld_q && (cap_idx_q == IDX_W'(gi))) begin
                    work_q[gi] <= rom.rom_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    display_q[gi] <= '0;
                end else if (disp_clear) begin
                    display_q[gi] <= '0;
                end else if (disp_load) begin
                    display_q[gi] <= (gi == NUM_DIGITS - 1) ? rom.rom_data : work_q[gi];
                end
            end
        end
    endgenerate

    assign x_off = pixel_x - X_LO;
    assign in_x  = (pixel_x >= X_LO) && (pixel_x < X_HI);

    always_comb begin
        pix_bit = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (x_off[9:3] == 7'(d)) pix_bit = display_q[d][~x_off[2:0]];
        end
    end

    assign pixel_on_d   = pixel_active && in_x && pix_bit;
    assign busy         = busy_q;
    assign pixel_on     = pixel_on_q;
    assign rom.rom_addr = rom_addr_q;

endmodule
